// File: rtl/ccff_stream_loader.sv
// Configuration-chain loader: takes bitstream words over valid/ready, shifts them MSB-first
// into a CCFF chain, and folds the bits leaving the chain tail into a readback parity.
module ccff_stream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 36,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_loaded,
  output logic              tail_parity
);

  localparam int NB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shift_reg;
  logic [NB_W-1:0]   nbits;
  logic [CNT_W-1:0]  remaining;
  logic              last_bit;
  logic              chain_full;

  always_comb begin
    remaining  = CNT_W'(CHAIN_LEN) - bits_loaded;
    last_bit   = (nbits == NB_W'(1));
    chain_full = ((bits_loaded + CNT_W'(1)) == CNT_W'(CHAIN_LEN));
  end

  // NOTE: every state and output register is written with <= so all of them see the
  // pre-edge values of each other, which is what makes the registered outputs line up.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state         <= IDLE;
      shift_reg     <= '0;
      nbits         <= '0;
      word_ready    <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bits_loaded   <= '0;
      tail_parity   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= WAIT;
            bits_loaded <= '0;
            tail_parity <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            word_ready  <= 1'b1;
          end
        end
        WAIT: begin
          if (word_valid && word_ready) begin
            state         <= SHIFT;
            word_ready    <= 1'b0;
            ccff_shift_en <= 1'b1;
            // The head flop presents the MSB now; the register keeps the bits still to come.
            ccff_head     <= word_data[WORD_W-1];
            shift_reg     <= word_data << 1;
            nbits         <= (remaining < CNT_W'(WORD_W)) ? remaining[NB_W-1:0]
                                                          : NB_W'(WORD_W);
          end
        end
        SHIFT: begin
          shift_reg   <= shift_reg << 1;
          nbits       <= nbits - NB_W'(1);
          bits_loaded <= bits_loaded + CNT_W'(1);
          tail_parity <= tail_parity ^ ccff_tail;
          if (last_bit) begin
            ccff_shift_en <= 1'b0;
            ccff_head     <= 1'b0;
            if (chain_full) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= WAIT;
              word_ready <= 1'b1;
            end
          end else begin
            ccff_head <= shift_reg[WORD_W-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: a 36-bit chain instance with a behavioural chain model and
// a 16-bit instance; expected head bits are queued at each handshake and popped per shift.
module tb_ccff_stream_loader;

  logic prog_clk = 1'b0;
  logic prog_reset;
  always #5 prog_clk = ~prog_clk;

  // 36-bit chain instance
  logic       start_a, valid_a, ready_a, head_a, shift_en_a, tail_a, busy_a, done_a, par_out_a;
  logic [7:0] data_a;
  logic [15:0] bits_a;
  logic [35:0] chain_a = '0;

  // 16-bit chain instance
  logic       start_b, valid_b, ready_b, head_b, shift_en_b, busy_b, done_b, par_out_b;
  logic [7:0] data_b;
  logic [15:0] bits_b;

  ccff_stream_loader #(.WORD_W(8), .CHAIN_LEN(36), .CNT_W(16)) dut_a (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a),
    .word_data(data_a), .word_valid(valid_a), .word_ready(ready_a),
    .ccff_head(head_a), .ccff_shift_en(shift_en_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .bits_loaded(bits_a), .tail_parity(par_out_a)
  );

  ccff_stream_loader #(.WORD_W(8), .CHAIN_LEN(16), .CNT_W(16)) dut_b (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b),
    .word_data(data_b), .word_valid(valid_b), .word_ready(ready_b),
    .ccff_head(head_b), .ccff_shift_en(shift_en_b), .ccff_tail(1'b0),
    .busy(busy_b), .done(done_b), .bits_loaded(bits_b), .tail_parity(par_out_b)
  );

  // Behavioural configuration chain behind dut_a.
  always @(posedge prog_clk) if (shift_en_a) chain_a <= {chain_a[34:0], head_a};
  assign tail_a = chain_a[35];

  int n_checks = 0;
  int n_fail   = 0;
  bit q_a[$];
  bit q_b[$];
  int pushed_a, pushed_b, shifts_a, shifts_b, hs_a, hs_b, sh0_a, hs0_a, sh0_b, hs0_b;
  bit hs_a_seen, hs_b_seen, par_a, load_xor_a, prev_xor_a;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard work on the falling edge, return just after the rising edge.
  task automatic step();
    int n;
    @(negedge prog_clk);
    hs_a_seen = 1'b0;
    hs_b_seen = 1'b0;
    if (shift_en_a) begin
      shifts_a++;
      par_a ^= tail_a;
      if (q_a.size() == 0) check("a_extra_shift", 1, 0);
      else check("a_head", 32'(head_a), 32'(q_a.pop_front()));
    end
    if (valid_a && ready_a) begin
      hs_a++;
      hs_a_seen = 1'b1;
      n = (36 - pushed_a < 8) ? 36 - pushed_a : 8;
      for (int i = 0; i < n; i++) begin
        q_a.push_back(data_a[7-i]);
        load_xor_a ^= data_a[7-i];
      end
      pushed_a += n;
    end
    if (shift_en_b) begin
      shifts_b++;
      if (q_b.size() == 0) check("b_extra_shift", 1, 0);
      else check("b_head", 32'(head_b), 32'(q_b.pop_front()));
    end
    if (valid_b && ready_b) begin
      hs_b++;
      hs_b_seen = 1'b1;
      n = (16 - pushed_b < 8) ? 16 - pushed_b : 8;
      for (int i = 0; i < n; i++) q_b.push_back(data_b[7-i]);
      pushed_b += n;
    end
    @(posedge prog_clk);
    #1;
  endtask

  task automatic begin_load_a();
    prev_xor_a = load_xor_a;
    load_xor_a = 1'b0;
    pushed_a   = 0;
    par_a      = 1'b0;
    sh0_a      = shifts_a;
    hs0_a      = hs_a;
    start_a    = 1'b1;
    step();
    start_a    = 1'b0;
    check("a_start_busy", 32'(busy_a), 1);
    check("a_start_bits", 32'(bits_a), 0);
  endtask

  task automatic send_a(logic [7:0] w);
    bit ok = 1'b0;
    valid_a = 1'b1;
    data_a  = w;
    for (int i = 0; i < 100; i++) begin
      step();
      if (hs_a_seen) begin ok = 1'b1; break; end
    end
    if (!ok) check("a_handshake_timeout", 0, 1);
  endtask

  task automatic send_b(logic [7:0] w);
    bit ok = 1'b0;
    valid_b = 1'b1;
    data_b  = w;
    for (int i = 0; i < 100; i++) begin
      step();
      if (hs_b_seen) begin ok = 1'b1; break; end
    end
    if (!ok) check("b_handshake_timeout", 0, 1);
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 200 && !done_a; i++) step();
    if (!done_a) check("a_done_timeout", 0, 1);
  endtask

  task automatic check_full_load_a(string tag);
    check({tag, "_done"}, 32'(done_a), 1);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_bits"}, 32'(bits_a), 36);
    check({tag, "_shifts"}, 32'(shifts_a - sh0_a), 36);
    check({tag, "_handshakes"}, 32'(hs_a - hs0_a), 5);
    check({tag, "_queue_empty"}, 32'(q_a.size()), 0);
    check({tag, "_tail_parity"}, 32'(par_out_a), 32'(par_a));
  endtask

  initial begin
    logic [15:0] b0;
    prog_reset = 1'b1;
    {start_a, valid_a, start_b, valid_b} = '0;
    data_a = '0;
    data_b = '0;
    repeat (2) step();
    prog_reset = 1'b0;
    step();
    check("rst_ready", 32'(ready_a), 0);
    check("rst_head", 32'(head_a), 0);
    check("rst_shift_en", 32'(shift_en_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_bits", 32'(bits_a), 0);
    check("rst_parity", 32'(par_out_a), 0);
    check("rst_b_ready", 32'(ready_b), 0);

    // Load P with valid held high; low nibble of the last word must be dropped.
    begin_load_a();
    check("a_wait_ready", 32'(ready_a), 1);
    send_a(8'hA5);
    send_a(8'h3C);
    send_a(8'hFF);
    send_a(8'h00);
    send_a(8'h9C);
    data_a = 8'h77;
    wait_done_a();
    check_full_load_a("p");
    repeat (10) step();
    check("p_no_extra_handshake", 32'(hs_a - hs0_a), 5);
    check("p_ready_low_in_done", 32'(ready_a), 0);
    check("p_bits_hold", 32'(bits_a), 36);
    valid_a = 1'b0;

    // Load Q: starvation after the first word, then a start pulse mid-shift.
    begin_load_a();
    send_a(8'h5A);
    valid_a = 1'b0;
    for (int i = 0; i < 100 && !ready_a; i++) step();
    check("q_back_to_wait", 32'(ready_a), 1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("q_starve_shift_en", 32'(shift_en_a), 0);
      check("q_starve_bits", 32'(bits_a), 8);
    end
    send_a(8'hC3);
    step();
    b0 = bits_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    check("q_start_ignored_cnt", 32'(bits_a > b0), 1);
    check("q_start_ignored_busy", 32'(busy_a), 1);
    send_a(8'h07);
    send_a(8'h81);
    send_a(8'hF0);
    valid_a = 1'b0;
    wait_done_a();
    check_full_load_a("q");
    check("q_readback_of_p", 32'(par_out_a), 32'(prev_xor_a));

    // Load R, reset asynchronously after 17 bits, then restart a full load.
    begin_load_a();
    send_a(8'($urandom_range(0, 255)));
    send_a(8'($urandom_range(0, 255)));
    send_a(8'($urandom_range(0, 255)));
    for (int i = 0; i < 20 && bits_a != 16'd17; i++) step();
    check("r_reached_17", 32'(bits_a), 17);
    #2 prog_reset = 1'b1;
    #1;
    check("r_rst_shift_en", 32'(shift_en_a), 0);
    check("r_rst_busy", 32'(busy_a), 0);
    check("r_rst_ready", 32'(ready_a), 0);
    check("r_rst_bits", 32'(bits_a), 0);
    q_a.delete();
    valid_a = 1'b0;
    step();
    prog_reset = 1'b0;
    step();
    begin_load_a();
    for (int i = 0; i < 5; i++) send_a(8'($urandom_range(0, 255)));
    valid_a = 1'b0;
    wait_done_a();
    check_full_load_a("s");

    // 16-bit chain: two words, nothing discarded, a third word never accepted.
    pushed_b = 0;
    sh0_b    = shifts_b;
    hs0_b    = hs_b;
    start_b  = 1'b1;
    step();
    start_b  = 1'b0;
    send_b(8'hB7);
    send_b(8'h4E);
    data_b = 8'h11;
    for (int i = 0; i < 100 && !done_b; i++) step();
    check("b_done", 32'(done_b), 1);
    check("b_bits", 32'(bits_b), 16);
    check("b_shifts", 32'(shifts_b - sh0_b), 16);
    check("b_handshakes", 32'(hs_b - hs0_b), 2);
    check("b_queue_empty", 32'(q_b.size()), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("b_third_word_ready", 32'(ready_b), 0);
    end
    check("b_no_third_handshake", 32'(hs_b - hs0_b), 2);
    valid_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
